ones_frame_counter: RTL and testbench

- Counts the '1' bits in a serial bit stream over a frame of programmable length, on a single clock.
- Parametrised successor of the fixed 4-bit ones counter. Generalised in counter width and frame length.
- Adds frame start/abort control, a done pulse, a held result, overflow flagging and a selectable saturate/wrap mode.
- Sits between a serial front-end (bit_valid/bit_in source) and status logic that samples count on done.

---
 rtl/ones_cnt_pkg.sv | 20 ++
 rtl/sat_counter.sv | 45 ++++
 rtl/ones_frame_counter.sv | 119 +++++++++++
 tb/tb_ones_frame_counter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ones_cnt_pkg.sv
// Shared types and helpers for the frame ones counter.
package ones_cnt_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCount,
    StDone
  } state_e;

  // Ceiling log2, never below 1 so an index register always has at least one bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Generic up-counter with synchronous clear and selectable saturate/wrap at all-ones.
module sat_counter #(
  parameter int unsigned CNT_W    = 4,
  parameter bit          SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_nxt,
  output logic             at_max
);

  localparam logic [CNT_W-1:0] MaxVal = '1;

  logic [CNT_W-1:0] count_q;

  assign at_max = (count_q == MaxVal);
  assign count  = count_q;

  // Next value: clear beats enable; at max either hold or roll over to zero.
  always_comb begin
    count_nxt = count_q;
    if (clear) begin
      count_nxt = '0;
    end else if (enable) begin
      if (at_max) begin
        count_nxt = SATURATE ? MaxVal : '0;
      end else begin
        count_nxt = count_q + CNT_W'(1);
      end
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_nxt;
    end
  end

endmodule

// File: rtl/ones_frame_counter.sv
// Counts '1' bits over a frame of FRAME_LEN accepted serial bits; publishes a held result
// and overflow flag with a one-cycle done pulse.
module ones_frame_counter
  import ones_cnt_pkg::*;
#(
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned FRAME_LEN = 8,
  parameter bit          SATURATE  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic             busy,
  output logic [CNT_W-1:0] running,
  output logic [CNT_W-1:0] count,
  output logic             done,
  output logic             overflow
);

  localparam int unsigned       IdxW    = clog2(FRAME_LEN);
  localparam logic [IdxW-1:0]   LastIdx = IdxW'(FRAME_LEN - 1);

  state_e           state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  logic             run_clear;
  logic             run_inc;
  logic             run_at_max;
  logic [CNT_W-1:0] running_nxt;

  sat_counter #(
    .CNT_W    (CNT_W),
    .SATURATE (SATURATE)
  ) u_running (
    .clk       (clk),
    .reset     (reset),
    .clear     (run_clear),
    .enable    (run_inc),
    .count     (running),
    .count_nxt (running_nxt),
    .at_max    (run_at_max)
  );

  // Next-state, index, sticky overflow and result capture.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    ovf_d      = ovf_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    run_clear  = 1'b0;
    run_inc    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StCount;
          idx_d     = '0;
          ovf_d     = 1'b0;
          run_clear = 1'b1;
        end
      end
      StCount: begin
        if (abort) begin
          // Abort wins over a coincident final bit: no result is published.
          state_d   = StIdle;
          idx_d     = '0;
          run_clear = 1'b1;
        end else if (bit_valid) begin
          idx_d   = idx_q + IdxW'(1);
          run_inc = bit_in;
          if (bit_in && run_at_max) begin
            ovf_d = 1'b1;
          end
          if (idx_q == LastIdx) begin
            // Capture includes this final bit, so take the counter's next value.
            state_d    = StDone;
            count_d    = running_nxt;
            overflow_d = ovf_q | (bit_in & run_at_max);
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      ovf_q      <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      ovf_q      <= ovf_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = (state_q == StCount);
  assign done     = (state_q == StDone);
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_ones_frame_counter.sv
// Bench for ones_frame_counter: three instances (4/8/sat, 3/10/sat, 3/10/wrap) share one
// stimulus stream and are each compared every cycle against a frame-level reference model.
module tb_ones_frame_counter;

  logic clk = 1'b0;
  logic reset, start, abort, bit_valid, bit_in;

  logic       busy0, done0, ovf0;
  logic [3:0] run0, cnt0;
  logic       busy1, done1, ovf1;
  logic [2:0] run1, cnt1;
  logic       busy2, done2, ovf2;
  logic [2:0] run2, cnt2;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  ones_frame_counter #(.CNT_W(4), .FRAME_LEN(8), .SATURATE(1'b1)) dut0 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .bit_valid(bit_valid),
    .bit_in(bit_in), .busy(busy0), .running(run0), .count(cnt0), .done(done0),
    .overflow(ovf0)
  );

  ones_frame_counter #(.CNT_W(3), .FRAME_LEN(10), .SATURATE(1'b1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .bit_valid(bit_valid),
    .bit_in(bit_in), .busy(busy1), .running(run1), .count(cnt1), .done(done1),
    .overflow(ovf1)
  );

  ones_frame_counter #(.CNT_W(3), .FRAME_LEN(10), .SATURATE(1'b0)) dut2 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .bit_valid(bit_valid),
    .bit_in(bit_in), .busy(busy2), .running(run2), .count(cnt2), .done(done2),
    .overflow(ovf2)
  );

  // Reference model: per instance, the frame phase plus how many bits and ones were accepted.
  int fl[3] = '{8, 10, 10};
  int mx[3] = '{15, 7, 7};
  bit sat[3] = '{1'b1, 1'b1, 1'b0};
  int ph[3];     // 0 idle, 1 counting, 2 done cycle
  int nb[3];
  int on[3];
  int mrun[3];
  int mcnt[3];
  bit mdn[3];
  bit mov[3];

  function automatic int ones_to_count(input int i, input int ones);
    if (sat[i]) return (ones > mx[i]) ? mx[i] : ones;
    return ones % (mx[i] + 1);
  endfunction

  task automatic model_step(input int i, input logic r, s, a, v, b);
    if (r) begin
      ph[i] = 0; nb[i] = 0; on[i] = 0; mrun[i] = 0; mcnt[i] = 0; mdn[i] = 0; mov[i] = 0;
      return;
    end
    mdn[i] = 1'b0;
    case (ph[i])
      0: if (s) begin
        ph[i] = 1; nb[i] = 0; on[i] = 0; mrun[i] = 0;
      end
      1: if (a) begin
        ph[i] = 0; nb[i] = 0; on[i] = 0; mrun[i] = 0;
      end else if (v) begin
        nb[i]++;
        on[i] += int'(b);
        mrun[i] = ones_to_count(i, on[i]);
        if (nb[i] == fl[i]) begin
          ph[i] = 2; mdn[i] = 1'b1; mcnt[i] = mrun[i]; mov[i] = (on[i] > mx[i]);
        end
      end
      default: ph[i] = 0;
    endcase
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                  nm, act, act, exp, exp, $time);
  endtask

  // Pack {busy, running, count, done, overflow} into one value for whole-state comparison.
  function automatic int pack(input logic bz, input logic [3:0] r, input logic [3:0] c,
                              input logic d, input logic o);
    return int'({bz, r, c, d, o});
  endfunction

  task automatic compare_model();
    for (int i = 0; i < 3; i++) begin
      int act;
      int exp;
      exp = pack(ph[i] == 1, 4'(mrun[i]), 4'(mcnt[i]), mdn[i], mov[i]);
      case (i)
        0: act = pack(busy0, run0, cnt0, done0, ovf0);
        1: act = pack(busy1, {1'b0, run1}, {1'b0, cnt1}, done1, ovf1);
        default: act = pack(busy2, {1'b0, run2}, {1'b0, cnt2}, done2, ovf2);
      endcase
      chk($sformatf("model_dut%0d{busy,run,cnt,done,ovf}", i), act, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model, then sample just after the edge.
  task automatic drive(input logic r, s, a, v, b);
    reset = r; start = s; abort = a; bit_valid = v; bit_in = b;
    for (int i = 0; i < 3; i++) model_step(i, r, s, a, v, b);
    @(posedge clk);
    #1;
    compare_model();
  endtask

  typedef struct {
    logic       r, s, a, v, b;
    logic       ebusy;
    logic [3:0] erun, ecnt;
    logic       edone, eovf;
  } vec_t;

  vec_t tbl[$];
  logic [7:0] pat = 8'b0100_1101;  // bit k is the k-th serial bit: 1,0,1,1,0,0,1,0

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;

    // Basic frame on the 4-bit/8-bit instance, expected outputs after each edge.
    tbl.push_back('{1, 0, 0, 0, 0, 0, 4'd0, 4'd0, 0, 0});
    tbl.push_back('{0, 1, 0, 0, 0, 1, 4'd0, 4'd0, 0, 0});
    tbl.push_back('{0, 0, 0, 1, 1, 1, 4'd1, 4'd0, 0, 0});
    tbl.push_back('{0, 0, 0, 1, 0, 1, 4'd1, 4'd0, 0, 0});
    tbl.push_back('{0, 0, 0, 1, 1, 1, 4'd2, 4'd0, 0, 0});
    tbl.push_back('{0, 0, 0, 1, 1, 1, 4'd3, 4'd0, 0, 0});
    tbl.push_back('{0, 0, 0, 1, 0, 1, 4'd3, 4'd0, 0, 0});
    tbl.push_back('{0, 0, 0, 1, 0, 1, 4'd3, 4'd0, 0, 0});
    tbl.push_back('{0, 0, 0, 1, 1, 1, 4'd4, 4'd0, 0, 0});
    tbl.push_back('{0, 0, 0, 1, 0, 0, 4'd4, 4'd4, 1, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 4'd4, 4'd4, 0, 0});
    tbl.push_back('{0, 0, 1, 1, 1, 0, 4'd4, 4'd4, 0, 0});
    foreach (tbl[k]) begin
      drive(tbl[k].r, tbl[k].s, tbl[k].a, tbl[k].v, tbl[k].b);
      chk($sformatf("tbl[%0d]{busy,run,cnt,done,ovf}", k),
          pack(busy0, run0, cnt0, done0, ovf0),
          pack(tbl[k].ebusy, tbl[k].erun, tbl[k].ecnt, tbl[k].edone, tbl[k].eovf));
    end

    // Reset mid-frame clears everything, including the held count of 4.
    drive(0, 1, 0, 0, 0);
    for (int k = 0; k < 3; k++) drive(0, 0, 0, 1, 1);
    drive(1, 0, 0, 0, 0);
    chk("rst_mid_running", int'(run0), 0);
    chk("rst_mid_busy", int'(busy0), 0);
    chk("rst_mid_count", int'(cnt0), 0);
    chk("rst_mid_done", int'(done0), 0);

    // Gapped stream with bit_in high in gaps and a stray start mid-frame.
    drive(0, 1, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      int gaps;
      gaps = $urandom_range(1, 3);
      for (int g = 0; g < gaps; g++) drive(0, (k == 3 && g == 0), 0, 0, 1);
      if (k == 7) chk("gap_busy_before_last", int'(busy0), 1);
      drive(0, 0, 0, 1, pat[k]);
    end
    chk("gap_done", int'(done0), 1);
    chk("gap_count", int'(cnt0), 4);
    drive(0, 0, 0, 0, 0);
    chk("gap_idle_busy", int'(busy0), 0);

    // Ten ones: 3-bit saturating stops at 7, wrapping ends at 2, both overflow.
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      drive(0, 0, 0, 1, 1);
      if (k == 8) chk("sat_running_held", int'(run1), 7);
    end
    chk("sat_done", int'(done1), 1);
    chk("sat_count", int'(cnt1), 7);
    chk("sat_ovf", int'(ovf1), 1);
    chk("wrap_count", int'(cnt2), 2);
    chk("wrap_ovf", int'(ovf2), 1);
    chk("wide_count", int'(cnt0), 8);
    chk("wide_ovf", int'(ovf0), 0);

    // Abort after a good frame keeps the old result and clears running.
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    for (int k = 0; k < 8; k++) drive(0, 0, 0, 1, pat[k]);
    drive(0, 0, 0, 0, 0);
    chk("abort_prev_count", int'(cnt0), 4);
    drive(0, 1, 0, 0, 0);
    for (int k = 0; k < 5; k++) drive(0, 0, 0, 1, 1);
    drive(0, 0, 1, 0, 0);
    chk("abort_done", int'(done0), 0);
    chk("abort_count", int'(cnt0), 4);
    chk("abort_running", int'(run0), 0);
    chk("abort_busy", int'(busy0), 0);
    drive(0, 0, 0, 0, 0);
    chk("abort_no_late_done", int'(done0), 0);

    // Abort coincident with the final bit: no result.
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    for (int k = 0; k < 7; k++) drive(0, 0, 0, 1, 1);
    drive(0, 0, 1, 1, 1);
    chk("abort_last_done", int'(done0), 0);
    chk("abort_last_busy", int'(busy0), 0);
    drive(0, 0, 0, 0, 0);
    chk("abort_last_no_late_done", int'(done0), 0);
    chk("abort_last_count", int'(cnt0), 0);

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      logic r, s, a, v, b;
      r = ($urandom_range(0, 199) == 0);
      s = ($urandom_range(0, 3) == 0);
      a = ($urandom_range(0, 39) == 0);
      v = ($urandom_range(0, 2) != 0);
      b = ($urandom_range(0, 3) != 0);
      drive(r, s, a, v, b);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
